// File: rtl/fetch_pkt_queue_pkg.sv
// Shared fetch-side constants for the fetch-to-decode packet queue.
package fetch_pkt_queue_pkg;
  localparam int FETCH_PKT_W   = 128;
  localparam int FETCH_Q_DEPTH = 4;
endpackage

// File: rtl/fetch_pkt_ptr.sv
// Wrap-around pointer: increments modulo 2**AW, synchronous clear beats increment.
module fetch_pkt_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/fetch_pkt_queue.sv
// Circular packet queue between fetch and decode with early stall and sticky overflow.
module fetch_pkt_queue
  import fetch_pkt_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int PKT_W = FETCH_PKT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PKT_W-1:0]         packet_in,
  input  logic                     packet_in_valid,
  input  logic                     resteer,
  input  logic                     is_init,
  input  logic                     D_ready,
  output logic [PKT_W-1:0]         packet_out,
  output logic                     packet_out_valid,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  logic [DEPTH-1:0][PKT_W-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic [CW-1:0]               count_q;
  logic                        flush, full, pop, push, drop;

  assign flush = resteer | is_init;
  assign full  = (count_q == FULL_CNT);
  assign pop   = packet_out_valid & D_ready & ~flush;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push  = packet_in_valid & ~flush & (~full | pop);
  assign drop  = packet_in_valid & ~flush & full & ~pop;

  fetch_pkt_ptr #(.AW(AW)) u_wptr (
    .clk(clk), .reset(reset), .clr(flush), .inc(push), .ptr(wptr)
  );
  fetch_pkt_ptr #(.AW(AW)) u_rptr (
    .clk(clk), .reset(reset), .clr(flush), .inc(pop), .ptr(rptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            count_q <= '0;
    else if (flush)        count_q <= '0;
    else if (push && !pop) count_q <= count_q + 1'b1;
    else if (pop && !push) count_q <= count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     overflow_err <= 1'b0;
    else if (drop)  overflow_err <= 1'b1;
  end

  // Storage is not reset; validity comes only from count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= packet_in;
  end

  assign packet_out       = mem[rptr];
  assign packet_out_valid = (count_q != '0);
  assign stall            = (count_q >= STALL_CNT);
  assign count            = count_q;
endmodule

// File: tb/tb_fetch_pkt_queue.sv
// Scoreboard bench for fetch_pkt_queue: a queue model tracks contents, head, count and overflow.
module tb_fetch_pkt_queue;
  localparam int DEPTH = 4;
  localparam int PKT_W = 128;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [PKT_W-1:0] packet_in = '0;
  logic             packet_in_valid = 1'b0;
  logic             resteer = 1'b0;
  logic             is_init = 1'b0;
  logic             D_ready = 1'b0;
  logic [PKT_W-1:0] packet_out;
  logic             packet_out_valid;
  logic             stall;
  logic [2:0]       count;
  logic             overflow_err;

  fetch_pkt_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clk(clk), .reset(reset), .packet_in(packet_in), .packet_in_valid(packet_in_valid),
    .resteer(resteer), .is_init(is_init), .D_ready(D_ready), .packet_out(packet_out),
    .packet_out_valid(packet_out_valid), .stall(stall), .count(count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [PKT_W-1:0] sb[$];
  logic             ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    chk("valid", packet_out_valid, sb.size() != 0);
    chk("count", count, sb.size());
    chk("stall", stall, sb.size() >= DEPTH - 1);
    chk("ovf", overflow_err, ovf_m);
    chk("cnt_le_depth", count <= DEPTH, 1);
    if (sb.size() != 0) chk("head", packet_out, sb[0]);
  endtask

  // Drive one cycle from posedge+1, check outputs, then advance the model at the edge.
  task automatic cyc(input logic v, input logic [PKT_W-1:0] p, input logic rdy,
                     input logic rs, input logic ini);
    logic fl, pop, push, full;
    packet_in_valid = v; packet_in = p; D_ready = rdy; resteer = rs; is_init = ini;
    #1;
    observe();
    fl   = rs | ini;
    full = (sb.size() == DEPTH);
    pop  = !fl && rdy && (sb.size() != 0);
    push = !fl && v && (!full || pop);
    if (!fl && v && full && !pop) ovf_m = 1'b1;
    @(posedge clk); #1;
    if (fl) sb.delete();
    else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back(p);
    end
    packet_in_valid = 1'b0; D_ready = 1'b0; resteer = 1'b0; is_init = 1'b0;
  endtask

  function automatic logic [PKT_W-1:0] mkpkt(input int n);
    return {4{32'(n) ^ 32'h5EED_0000}};
  endfunction

  initial begin
    logic [PKT_W-1:0] p0;
    p0 = {16{8'hA5}};
    #1;
    observe();                                  // reset state
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // single push, head visible next cycle
    cyc(1, p0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0);

    // fill to full, stall early, overflow on fifth
    cyc(0, '0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) cyc(1, mkpkt(i), 0, 0, 0);
    cyc(0, '0, 0, 0, 0);

    // push + pop at full: count held, new entry at wrapped wptr, then drain
    cyc(1, mkpkt(6), 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);

    // resteer with push and pop at count=2
    cyc(1, mkpkt(7), 0, 0, 0);
    cyc(1, mkpkt(8), 0, 0, 0);
    cyc(1, mkpkt(9), 1, 1, 0);
    cyc(0, '0, 1, 0, 0);

    // is_init and both flush sources together
    cyc(1, mkpkt(10), 0, 0, 0);
    cyc(1, mkpkt(11), 1, 0, 1);
    cyc(1, mkpkt(12), 0, 0, 0);
    cyc(1, mkpkt(13), 0, 1, 1);
    cyc(0, '0, 0, 0, 0);

    // streaming with D_ready toggling, across pointer wrap
    for (int i = 0; i < 10; i++) cyc(1, mkpkt(20 + i), logic'(i[0]), 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, '0, 1, 0, 0);
    cyc(1, mkpkt(40), 0, 0, 0);
    cyc(1, mkpkt(41), 1, 0, 0);

    // async reset mid-cycle at count=3 with overflow set
    for (int i = 0; i < 8; i++) cyc(1, mkpkt(50 + i), 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    ovf_m = 1'b0;
    observe();
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1, mkpkt(60), 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_pkt_queue.md
FETCH_PKT_QUEUE -- requirements
Module: fetch_pkt_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of packet entries; power of two, at least 4.
REQ-002 Parameter: PKT_W, 128, packet width in bits.
REQ-003 Port: clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 Port: reset, input, 1, asynchronous active-low reset.
REQ-005 Port: packet_in, input, PKT_W, fetch-stage packet (fetch packet_out).
REQ-006 Port: packet_in_valid, input, 1, packet_in carries a packet this cycle.
REQ-007 Port: resteer, input, 1, writeback redirect; flushes queue.
REQ-008 Port: is_init, input, 1, init-sequence redirect; flushes queue.
REQ-009 Port: D_ready, input, 1, decode accepts head packet this cycle.
REQ-010 Port: packet_out, output, PKT_W, head packet to decode.
REQ-011 Port: packet_out_valid, output, 1, packet_out holds a valid packet.
REQ-012 Port: stall, output, 1, backpressure to fetch (drives fetch stall input).
REQ-013 Port: count, output, log2(DEPTH)+1, current occupancy.
REQ-014 Port: overflow_err, output, 1, sticky: a valid push was dropped while full.

Function
REQ-015 Circular buffer: write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-016 Push: packet_in_valid=1, no flush, and (count<DEPTH or pop this cycle) -> write entry at wptr, wptr+1.
REQ-017 Pop: packet_out_valid=1 and D_ready=1, no flush -> rptr+1.
REQ-018 count next = count + push - pop; simultaneous push and pop leaves count unchanged, including at full and at count=1.
REQ-019 packet_out = entry at rptr, combinational from registered storage; packet_out_valid = (count!=0); no empty-bypass, so push-to-valid latency is exactly 1 cycle.
REQ-020 stall = (count >= DEPTH-1), registered-state-derived; the one-entry margin absorbs the packet fetch launches in the cycle it observes stall.
REQ-021 Push with count==DEPTH and no pop: packet dropped, storage unchanged, overflow_err set and held until reset.
REQ-022 Pop with count==0: ignored; pointers and count unchanged.
REQ-023 Flush (resteer or is_init high at edge): wptr=rptr=0, count=0; same-cycle push and pop ignored; packet_out_valid=0 next cycle.
REQ-024 Flush takes priority over push and pop; resteer and is_init together behave as one flush.
REQ-025 Entry contents are not cleared on flush; validity derives only from count.

Reset
REQ-026 reset low asynchronously forces wptr=0, rptr=0, count=0, overflow_err=0; hence packet_out_valid=0 and stall=0 immediately.
REQ-027 Storage array is not reset; packet_out value is don't-care while packet_out_valid=0.
REQ-028 Reset asserted mid-operation discards all entries; first push after release is accepted on the first rising edge with reset high.

Structure
REQ-029 Shared fetch package holds PKT_W=128 and default queue depth constant; module parameters default from it.
REQ-030 One sub-module is natural: fetch_pkt_ptr (wrap-around pointer register with increment and synchronous clear), instantiated for wptr and rptr.
REQ-031 Target 120-400 lines RTL; no latches; single always-block per register group.

Verification
REQ-032 Reset, push P0=0xA5..A5 with D_ready=0 -> next cycle packet_out_valid=1, packet_out=P0, count=1, stall=0.
REQ-033 D_ready=0, push 3 packets -> count=3, stall=1 after third push; fourth push accepted -> count=4; fifth push -> dropped, overflow_err=1, count stays 4.
REQ-034 count=4, push and D_ready=1 same cycle -> count stays 4, head advances, new packet stored at wrapped wptr; drain 4 in order with no loss.
REQ-035 count=2, resteer=1 with push and D_ready=1 -> next cycle count=0, packet_out_valid=0, stall=0, pushed packet absent.
REQ-036 Run 10 pushes/pops with D_ready toggling every cycle -> output order equals input order across pointer wrap; count never exceeds 4.
REQ-037 count=3, assert reset low between clock edges -> count=0, stall=0, packet_out_valid=0 before next edge; overflow_err cleared.
